// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider (seq_divider).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Extra cycles between the accept edge and out_valid beyond WIDTH iterations.
  localparam int DIV_LAT_EXTRA = 0;

  function automatic int clog2_w(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left, trial-subtract.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    // Borrow out of the extra top bit means the trial went negative: restore.
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready in and out.
// Define DIV_SIGNED_EN to add the signed_mode port and two's-complement support.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DIV_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds its outputs.

  localparam int LAST_ITER = WIDTH - 1 + DIV_LAT_EXTRA;
  localparam int CW        = clog2_w(LAST_ITER + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             dbz_q, dbz_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_neg;
  logic             b_neg;

`ifdef DIV_SIGNED_EN
  always_comb begin
    a_neg = signed_mode && dividend[WIDTH-1];
    b_neg = signed_mode && divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor  : divisor;
  end
`else
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    a_mag = dividend;
    b_mag = divisor;
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            quot_d  = '1;
            remd_d  = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dbz_d   = 1'b0;
            cnt_d   = CW'(LAST_ITER);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        // Sign fix-up is folded into the final iteration so latency stays WIDTH.
        if (cnt_q == '0) begin
          cnt_d   = '0;
          quot_d  = qneg_q ? -step_quo : step_quo;
          remd_d  = rneg_q ? -step_rem : step_rem;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, multi-cycle corner
// sequences, and randomized traffic at WIDTH 8 and 16 against a / and % model.
module tb_seq_divider;

  localparam int W  = 8;
  localparam int W2 = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (WIDTH 8) ----------------
  logic          in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [W-1:0]  dividend, divisor, quotient, remainder;
`ifdef DIV_SIGNED_EN
  logic          signed_mode;
`endif

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef DIV_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // ---------------- DUT (WIDTH 16) ----------------
  logic          in_valid_w, in_ready_w, out_valid_w, out_ready_w, div_by_zero_w;
  logic [W2-1:0] dividend_w, divisor_w, quotient_w, remainder_w;
`ifdef DIV_SIGNED_EN
  logic          signed_mode_w;
`endif

  seq_divider #(.WIDTH(W2)) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef DIV_SIGNED_EN
    .signed_mode (signed_mode_w),
`endif
    .in_valid    (in_valid_w),
    .in_ready    (in_ready_w),
    .dividend    (dividend_w),
    .divisor     (divisor_w),
    .out_valid   (out_valid_w),
    .out_ready   (out_ready_w),
    .quotient    (quotient_w),
    .remainder   (remainder_w),
    .div_by_zero (div_by_zero_w)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W2:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain / and % on integers, sign-extended from w bits in signed mode.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, output logic [15:0] q, output logic [15:0] r,
                       output logic z);
    int sa, sb, iq, ir, mask;
    mask = (1 << w) - 1;
    sa = int'(a);
    sb = int'(b);
    if (sm && a[w-1]) sa = sa - (1 << w);
    if (sm && b[w-1]) sb = sb - (1 << w);
    if (b == 16'd0) begin
      q = 16'(mask);
      r = a;
      z = 1'b1;
    end else begin
      iq = sa / sb;
      ir = sa % sb;
      q = 16'(iq & mask);
      r = 16'(ir & mask);
      z = 1'b0;
    end
  endtask

  // ---------------- driver tasks (WIDTH 8) ----------------
  task automatic send8(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    signed_mode = sm;
`else
    if (sm) $display("note: signed request issued to an unsigned build");
`endif
    @(posedge clk); #1;
    // Operand noise after accept must be ignored.
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Counts edges after the accept edge until out_valid; also watches in_ready while busy.
  task automatic wait8(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic take8();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vt[$];

  task automatic run_vec(input vec_t v);
    int   lat;
    logic busy_ok;
    send8(v.a, v.b, v.sm);
    wait8(lat, busy_ok);
    chk($sformatf("lat %0d/%0d", v.a, v.b), 64'(lat), (v.b == 0) ? 64'd0 : 64'(W));
    if (v.b != 0) chk($sformatf("busy_in_ready %0d/%0d", v.a, v.b), {63'd0, busy_ok}, 64'd1);
    chk($sformatf("quot %0h/%0h", v.a, v.b), 64'(quotient), 64'(v.q));
    chk($sformatf("rem %0h/%0h", v.a, v.b), 64'(remainder), 64'(v.r));
    chk($sformatf("dbz %0h/%0h", v.a, v.b), {63'd0, div_by_zero}, {63'd0, v.z});
    take8();
    chk("out_valid_after_take", {63'd0, out_valid}, 64'd0);
    chk("in_ready_after_take", {63'd0, in_ready}, 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int            lat;
    logic          busy_ok;
    logic          sm;
    logic [15:0]   eq, er;
    logic          ez;
    logic [W-1:0]  ra, rb;
    logic [W2-1:0] ra_w, rb_w;
    logic [2*W2:0] exp;
    int            guard;

    in_valid = 0; out_ready = 0; dividend = '0; divisor = '0;
    in_valid_w = 0; out_ready_w = 0; dividend_w = '0; divisor_w = '0;
`ifdef DIV_SIGNED_EN
    signed_mode = 0; signed_mode_w = 0;
`endif

    vt.push_back('{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,  1'b0});
    vt.push_back('{8'd55,  8'd0,   1'b0, 8'hFF,  8'd55, 1'b1});
    vt.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,  1'b0});
    vt.push_back('{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,  1'b0});
    vt.push_back('{8'd5,   8'd255, 1'b0, 8'd0,   8'd5,  1'b0});
    vt.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,  1'b0});
    vt.push_back('{8'd100, 8'd9,   1'b0, 8'd11,  8'd1,  1'b0});
`ifdef DIV_SIGNED_EN
    vt.push_back('{8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0});
    vt.push_back('{8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0});
    vt.push_back('{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0});
    vt.push_back('{8'h80, 8'h00, 1'b1, 8'hFF, 8'h80, 1'b1});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (vt[i]) run_vec(vt[i]);

    // Backpressure: hold the 9/3 result for 5 cycles
    send8(8'd9, 8'd3, 1'b0);
    wait8(lat, busy_ok);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      chk($sformatf("bp_valid c%0d", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp_quot c%0d", k), 64'(quotient), 64'd3);
      chk($sformatf("bp_rem c%0d", k), 64'(remainder), 64'd0);
      chk($sformatf("bp_in_ready c%0d", k), {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    // in_valid stays high across the take edge: no accept may happen there
    dividend = 8'd50; divisor = 8'd5;
    take8();
    chk("bp_take_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_no_accept_on_take", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_next", {63'd0, in_ready}, 64'd0);
    wait8(lat, busy_ok);
    chk("bp_follow_quot", 64'(quotient), 64'd10);
    take8();

    // Reset mid-operation
    send8(8'd100, 8'd9, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send8(8'd100, 8'd9, 1'b0);
    wait8(lat, busy_ok);
    chk("midrst_redo_lat", 64'(lat), 64'(W));
    chk("midrst_redo_quot", 64'(quotient), 64'd11);
    chk("midrst_redo_rem", 64'(remainder), 64'd1);
    take8();

    // Random WIDTH 8
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
`ifdef DIV_SIGNED_EN
      sm = 1'($urandom_range(0, 1));
`else
      sm = 1'b0;
`endif
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send8(ra, rb, sm);
      model(W, 16'(ra), 16'(rb), sm, eq, er, ez);
      exp_q.push_back({eq, er, ez});
      wait8(lat, busy_ok);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      exp = exp_q.pop_front();
      chk($sformatf("rand8 %0h/%0h sm%0d", ra, rb, sm),
          64'({8'd0, quotient, 8'd0, remainder, div_by_zero}), 64'(exp));
      take8();
    end

    // Random WIDTH 16
    for (int i = 0; i < 1000; i++) begin
      ra_w = W2'($urandom);
      rb_w = ($urandom_range(0, 9) == 0) ? '0 :
             ($urandom_range(0, 1) == 0) ? W2'($urandom_range(1, 300)) : W2'($urandom);
`ifdef DIV_SIGNED_EN
      sm = 1'($urandom_range(0, 1));
      signed_mode_w = sm;
`else
      sm = 1'b0;
`endif
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      guard = 0;
      while (!in_ready_w && guard < 200) begin @(posedge clk); #1; guard++; end
      if (!in_ready_w) chk("in_ready_w_timeout", {63'd0, in_ready_w}, 64'd1);
      in_valid_w = 1'b1; dividend_w = ra_w; divisor_w = rb_w;
      @(posedge clk); #1;
      in_valid_w = 1'b0; dividend_w = W2'($urandom); divisor_w = W2'($urandom);
      model(W2, ra_w, rb_w, sm, eq, er, ez);
      exp_q.push_back({eq, er, ez});
      guard = 0;
      while (!out_valid_w && guard < 100) begin @(posedge clk); #1; guard++; end
      if (!out_valid_w) chk("out_valid_w_timeout", {63'd0, out_valid_w}, 64'd1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      exp = exp_q.pop_front();
      chk($sformatf("rand16 %0h/%0h sm%0d", ra_w, rb_w, sm),
          64'({quotient_w, remainder_w, div_by_zero_w}), 64'(exp));
      out_ready_w = 1'b1;
      @(posedge clk); #1;
      out_ready_w = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
